// File: rtl/rail_sequencer_if.sv
// Bundle between the rail sequencer and its surroundings: run/fault control in,
// per-rail power-good in, per-rail enables and status out.
interface rail_sequencer_if #(
  parameter int unsigned NUM_RAILS = 5
) ();
  logic                 start;
  logic [NUM_RAILS-1:0] pgood;
  logic                 fault_clr;
  logic [NUM_RAILS-1:0] act_ctl;
  logic [2:0]           state;
  logic                 all_good;
  logic                 fault;
  logic [2:0]           fault_rail;

  modport master (
    input  start, pgood, fault_clr,
    output act_ctl, state, all_good, fault, fault_rail
  );

  modport slave (
    output start, pgood, fault_clr,
    input  act_ctl, state, all_good, fault, fault_rail
  );
endinterface

// File: rtl/rail_sequencer.sv
// Power-rail sequencer: enables rails in index order after each power-good,
// sheds them in reverse on request, and drops everything on a power-good fault.
module rail_sequencer #(
  parameter int unsigned NUM_RAILS  = 5,
  parameter int unsigned STEP_DELAY = 4,
  parameter int unsigned PG_TIMEOUT = 16,
  parameter int unsigned TIMER_W    = 24
) (
  input  logic             clk,
  input  logic             n_rst,
  rail_sequencer_if.master bus
);

  localparam int unsigned IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RAMP     = 3'd1;
  localparam logic [2:0] ST_SETTLE   = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_SHUTDOWN = 3'd4;
  localparam logic [2:0] ST_FAULT    = 3'd5;

  localparam logic [TIMER_W-1:0] STEP_LAST = TIMER_W'(STEP_DELAY - 1);
  localparam logic [TIMER_W-1:0] PG_LAST   = TIMER_W'(PG_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_RAILS - 1);

  logic [2:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TIMER_W-1:0]   timer_q, timer_d, timer_inc;
  logic [NUM_RAILS-1:0] act_q, act_d;
  logic [NUM_RAILS-1:0] conf_q, conf_d;
  logic [2:0]           fault_rail_q, fault_rail_d;
  logic                 all_good_q, fault_q;

  logic [NUM_RAILS-1:0] bad;
  logic [NUM_RAILS-1:0] top_bit;
  logic [2:0]           low_bad;

  // Lost power-good on confirmed rails, and the highest still-enabled rail.
  always_comb begin
    bad     = conf_q & ~bus.pgood;
    low_bad = 3'd0;
    for (int i = int'(NUM_RAILS) - 1; i >= 0; i--) begin
      if (bad[i]) low_bad = 3'(i);
    end
    top_bit = '0;
    for (int i = 0; i < int'(NUM_RAILS); i++) begin
      if (act_q[i]) begin
        top_bit    = '0;
        top_bit[i] = 1'b1;
      end
    end
  end

  assign timer_inc = (&timer_q) ? timer_q : timer_q + TIMER_W'(1);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_inc;
    act_d        = act_q;
    conf_d       = conf_q;
    fault_rail_d = fault_rail_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RAMP;
          idx_d   = '0;
          act_d   = NUM_RAILS'(1);
          conf_d  = '0;
          timer_d = '0;
        end
      end

      ST_RAMP, ST_SETTLE, ST_RUN: begin
        if (|bad) begin
          state_d      = ST_FAULT;
          act_d        = '0;
          conf_d       = '0;
          fault_rail_d = low_bad;
        end else if (!bus.start) begin
          state_d = ST_SHUTDOWN;
          act_d   = act_q & ~top_bit;
          conf_d  = '0;
          timer_d = '0;
        end else if (state_q == ST_RAMP) begin
          // Power-good outranks a timeout expiring on the same edge.
          if (bus.pgood[idx_q]) begin
            state_d        = ST_SETTLE;
            conf_d[idx_q]  = 1'b1;
            timer_d        = '0;
          end else if (timer_q == PG_LAST) begin
            state_d      = ST_FAULT;
            act_d        = '0;
            conf_d       = '0;
            fault_rail_d = 3'(idx_q);
          end
        end else if (state_q == ST_SETTLE && timer_q == STEP_LAST) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_RAMP;
            idx_d   = idx_q + IDX_W'(1);
            act_d   = act_q | (NUM_RAILS'(1) << idx_d);
            timer_d = '0;
          end
        end
      end

      ST_SHUTDOWN: begin
        if (timer_q == STEP_LAST) begin
          timer_d = '0;
          if (|act_q) act_d   = act_q & ~top_bit;
          else        state_d = ST_IDLE;
        end
      end

      ST_FAULT: begin
        if (bus.fault_clr && !bus.start) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        act_d   = '0;
        conf_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      timer_q      <= '0;
      act_q        <= '0;
      conf_q       <= '0;
      fault_rail_q <= 3'd0;
      all_good_q   <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      act_q        <= act_d;
      conf_q       <= conf_d;
      fault_rail_q <= fault_rail_d;
      all_good_q   <= (state_d == ST_RUN);
      fault_q      <= (state_d == ST_FAULT);
    end
  end

  assign bus.act_ctl    = act_q;
  assign bus.state      = state_q;
  assign bus.all_good   = all_good_q;
  assign bus.fault      = fault_q;
  assign bus.fault_rail = fault_rail_q;

endmodule

// File: tb/tb_rail_sequencer.sv
// Self-checking bench for rail_sequencer: directed scenarios plus randomized
// power-good delays checked against a cycle-schedule model.
module tb_rail_sequencer;

  localparam int NR  = 5;
  localparam int SD  = 4;
  localparam int PGT = 16;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RAMP     = 3'd1;
  localparam logic [2:0] S_SETTLE   = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_SHUTDOWN = 3'd4;
  localparam logic [2:0] S_FAULT    = 3'd5;

  logic clk = 1'b0;
  logic n_rst;

  rail_sequencer_if #(.NUM_RAILS(NR)) bus ();

  rail_sequencer #(
    .NUM_RAILS (NR),
    .STEP_DELAY(SD),
    .PG_TIMEOUT(PGT),
    .TIMER_W   (24)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc      = 0;
  int chk_cnt  = 0;
  int pass_cnt = 0;
  int en_cyc[NR];
  int dly[NR];

  // One clock; then the PID stand-ins raise pgood[i] dly[i] cycles after act_ctl[i].
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (!bus.act_ctl[i])    en_cyc[i] = -1;
      else if (en_cyc[i] < 0) en_cyc[i] = cyc;
      bus.pgood[i] = (en_cyc[i] >= 0) && (cyc - en_cyc[i] >= dly[i]);
    end
  endtask

  task automatic set_dly(input int d);
    for (int i = 0; i < NR; i++) dly[i] = d;
  endtask

  task automatic apply_reset();
    n_rst         = 1'b0;
    bus.start     = 1'b0;
    bus.fault_clr = 1'b0;
    step();
    step();
    n_rst = 1'b1;
  endtask

  // Expected enables/state r cycles after start is first sampled high in IDLE.
  function automatic void model(input int r, output logic [NR-1:0] act, output logic [2:0] st);
    int t;
    t   = 1;
    act = '0;
    st  = S_IDLE;
    if (r < 1) return;
    for (int i = 0; i < NR; i++) begin
      act = NR'((1 << (i + 1)) - 1);
      if (dly[i] >= PGT) begin
        if (r >= t + PGT) begin
          act = '0;
          st  = S_FAULT;
        end else begin
          st = S_RAMP;
        end
        return;
      end
      if (r <= t + dly[i]) begin
        st = S_RAMP;
        return;
      end
      if (r < t + dly[i] + 1 + SD) begin
        st = S_SETTLE;
        return;
      end
      t = t + dly[i] + 1 + SD;
    end
    act = '1;
    st  = S_RUN;
  endfunction

  function automatic int timeout_rail();
    for (int i = 0; i < NR; i++) if (dly[i] >= PGT) return i;
    return -1;
  endfunction

  task automatic test_reset();
    n_rst     = 1'b0;
    bus.start = 1'b1;
    step();
    step();
    chk_cnt++; if (bus.state !== S_IDLE) $display("FAIL reset_state: got %0d expected %0d", bus.state, S_IDLE); else pass_cnt++;
    chk_cnt++; if (bus.act_ctl !== 5'b0) $display("FAIL reset_act: got %b expected 00000", bus.act_ctl); else pass_cnt++;
    chk_cnt++; if (bus.all_good !== 1'b0) $display("FAIL reset_all_good: got %b expected 0", bus.all_good); else pass_cnt++;
    chk_cnt++; if (bus.fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", bus.fault); else pass_cnt++;
    chk_cnt++; if (bus.fault_rail !== 3'd0) $display("FAIL reset_fault_rail: got %0d expected 0", bus.fault_rail); else pass_cnt++;
    bus.start = 1'b0;
    n_rst     = 1'b1;
    step();
  endtask

  task automatic test_power_up();
    logic [NR-1:0] ea;
    logic [2:0]    es;
    int t0;
    apply_reset();
    set_dly(3);
    bus.start = 1'b1;
    t0 = cyc;
    for (int r = 1; r <= 45; r++) begin
      step();
      model(cyc - t0, ea, es);
      chk_cnt++; if (bus.act_ctl !== ea) $display("FAIL pwrup_act@%0d: got %b expected %b", r, bus.act_ctl, ea); else pass_cnt++;
      chk_cnt++; if (bus.state !== es) $display("FAIL pwrup_state@%0d: got %0d expected %0d", r, bus.state, es); else pass_cnt++;
      chk_cnt++; if (bus.all_good !== (es == S_RUN)) $display("FAIL pwrup_all_good@%0d: got %b expected %b", r, bus.all_good, es == S_RUN); else pass_cnt++;
    end
  endtask

  task automatic test_droop();
    bus.pgood[1] = 1'b0;
    step();
    chk_cnt++; if (bus.state !== S_FAULT) $display("FAIL droop_state: got %0d expected %0d", bus.state, S_FAULT); else pass_cnt++;
    chk_cnt++; if (bus.act_ctl !== 5'b0) $display("FAIL droop_act: got %b expected 00000", bus.act_ctl); else pass_cnt++;
    chk_cnt++; if (bus.all_good !== 1'b0) $display("FAIL droop_all_good: got %b expected 0", bus.all_good); else pass_cnt++;
    chk_cnt++; if (bus.fault !== 1'b1) $display("FAIL droop_fault: got %b expected 1", bus.fault); else pass_cnt++;
    chk_cnt++; if (bus.fault_rail !== 3'd1) $display("FAIL droop_fault_rail: got %0d expected 1", bus.fault_rail); else pass_cnt++;
  endtask

  task automatic test_fault_clear();
    bus.fault_clr = 1'b1;
    bus.start     = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_cnt++; if (bus.state !== S_FAULT) $display("FAIL fclr_hold_state@%0d: got %0d expected %0d", k, bus.state, S_FAULT); else pass_cnt++;
      chk_cnt++; if (bus.fault !== 1'b1) $display("FAIL fclr_hold_fault@%0d: got %b expected 1", k, bus.fault); else pass_cnt++;
    end
    bus.start = 1'b0;
    step();
    chk_cnt++; if (bus.state !== S_IDLE) $display("FAIL fclr_state: got %0d expected %0d", bus.state, S_IDLE); else pass_cnt++;
    chk_cnt++; if (bus.fault !== 1'b0) $display("FAIL fclr_fault: got %b expected 0", bus.fault); else pass_cnt++;
    chk_cnt++; if (bus.fault_rail !== 3'd1) $display("FAIL fclr_rail_kept: got %0d expected 1", bus.fault_rail); else pass_cnt++;
    bus.fault_clr = 1'b0;
  endtask

  task automatic test_timeout();
    logic [NR-1:0] ea;
    logic [2:0]    es;
    int t0;
    apply_reset();
    set_dly(3);
    dly[2] = 100000;
    bus.start = 1'b1;
    t0 = cyc;
    for (int r = 1; r <= 34; r++) begin
      step();
      model(cyc - t0, ea, es);
      chk_cnt++; if (bus.act_ctl !== ea) $display("FAIL tmo_act@%0d: got %b expected %b", r, bus.act_ctl, ea); else pass_cnt++;
      chk_cnt++; if (bus.state !== es) $display("FAIL tmo_state@%0d: got %0d expected %0d", r, bus.state, es); else pass_cnt++;
      chk_cnt++; if (bus.fault !== (es == S_FAULT)) $display("FAIL tmo_fault@%0d: got %b expected %b", r, bus.fault, es == S_FAULT); else pass_cnt++;
    end
    chk_cnt++; if (bus.fault_rail !== 3'd2) $display("FAIL tmo_fault_rail: got %0d expected 2", bus.fault_rail); else pass_cnt++;
  endtask

  task automatic test_shutdown();
    logic [NR-1:0] ea;
    logic [2:0]    es;
    int k;
    int nb;
    apply_reset();
    set_dly(3);
    bus.start = 1'b1;
    repeat (45) step();
    bus.start = 1'b0;
    for (int r = 1; r <= 24; r++) begin
      step();
      bus.start = (r == 6);
      k  = (r - 1) / SD;
      nb = (NR - 1 - k > 0) ? NR - 1 - k : 0;
      ea = NR'((1 << nb) - 1);
      es = (r < 1 + SD * NR) ? S_SHUTDOWN : S_IDLE;
      chk_cnt++; if (bus.act_ctl !== ea) $display("FAIL shdn_act@%0d: got %b expected %b", r, bus.act_ctl, ea); else pass_cnt++;
      chk_cnt++; if (bus.state !== es) $display("FAIL shdn_state@%0d: got %0d expected %0d", r, bus.state, es); else pass_cnt++;
      chk_cnt++; if (bus.all_good !== 1'b0) $display("FAIL shdn_all_good@%0d: got %b expected 0", r, bus.all_good); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] ea;
    logic [2:0]    es;
    int t0;
    int tr;
    for (int it = 0; it < 8; it++) begin
      apply_reset();
      for (int i = 0; i < NR; i++) begin
        if (it == 0)                        dly[i] = PGT - 1;
        else if ($urandom_range(0, 5) == 0) dly[i] = PGT + int'($urandom_range(0, 3));
        else                                dly[i] = int'($urandom_range(0, PGT - 1));
      end
      bus.start = 1'b1;
      t0 = cyc;
      for (int r = 1; r <= NR * (PGT + SD) + 4; r++) begin
        step();
        model(cyc - t0, ea, es);
        chk_cnt++; if (bus.act_ctl !== ea) $display("FAIL rnd%0d_act@%0d: got %b expected %b", it, r, bus.act_ctl, ea); else pass_cnt++;
        chk_cnt++; if (bus.state !== es) $display("FAIL rnd%0d_state@%0d: got %0d expected %0d", it, r, bus.state, es); else pass_cnt++;
      end
      tr = timeout_rail();
      if (tr >= 0) begin
        chk_cnt++; if (bus.fault_rail !== 3'(tr)) $display("FAIL rnd%0d_fault_rail: got %0d expected %0d", it, bus.fault_rail, tr); else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] ea;
    logic [2:0]    es;
    int t0;
    apply_reset();
    set_dly(3);
    bus.start = 1'b1;
    repeat (18) step();
    chk_cnt++; if (bus.state !== S_RAMP) $display("FAIL rstmid_pre_state: got %0d expected %0d", bus.state, S_RAMP); else pass_cnt++;
    n_rst = 1'b0;
    step();
    chk_cnt++; if (bus.state !== S_IDLE) $display("FAIL rstmid_state: got %0d expected %0d", bus.state, S_IDLE); else pass_cnt++;
    chk_cnt++; if (bus.act_ctl !== 5'b0) $display("FAIL rstmid_act: got %b expected 00000", bus.act_ctl); else pass_cnt++;
    chk_cnt++; if (bus.all_good !== 1'b0) $display("FAIL rstmid_all_good: got %b expected 0", bus.all_good); else pass_cnt++;
    chk_cnt++; if (bus.fault !== 1'b0) $display("FAIL rstmid_fault: got %b expected 0", bus.fault); else pass_cnt++;
    chk_cnt++; if (bus.fault_rail !== 3'd0) $display("FAIL rstmid_fault_rail: got %0d expected 0", bus.fault_rail); else pass_cnt++;
    n_rst = 1'b1;
    t0 = cyc;
    for (int r = 1; r <= 12; r++) begin
      step();
      model(cyc - t0, ea, es);
      chk_cnt++; if (bus.act_ctl !== ea) $display("FAIL rstmid_restart_act@%0d: got %b expected %b", r, bus.act_ctl, ea); else pass_cnt++;
      chk_cnt++; if (bus.state !== es) $display("FAIL rstmid_restart_state@%0d: got %0d expected %0d", r, bus.state, es); else pass_cnt++;
    end
  endtask

  initial begin
    n_rst         = 1'b0;
    bus.start     = 1'b0;
    bus.fault_clr = 1'b0;
    bus.pgood     = '0;
    set_dly(3);
    for (int i = 0; i < NR; i++) en_cyc[i] = -1;

    test_reset();
    test_power_up();
    test_droop();
    test_fault_clear();
    test_timeout();
    test_shutdown();
    test_random();
    test_reset_mid();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
